imem_loader: RTL and testbench

Boot-time program loader for the single-cycle MIPS core. It accepts a byte stream with a valid/ready handshake and packs it into 32-bit big-endian instruction words. It writes those words sequentially into the instruction memory's write port, holding the CPU in reset until the image is complete. It is the writing end of the instruction memory, which the core only reads.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/imem_loader_if.sv | 29 ++
 rtl/byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
//   - loader_state_e : loader FSM states
//   - WORD_W, BYTE_W, BYTES_PER_WORD, IDX_W : packing geometry
//   - sum_add        : modulo-256 accumulate used by the optional checksum
package mips_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_e;

  // 8-bit wrap-around sum of stream bytes
  function automatic logic [BYTE_W-1:0] sum_add(input logic [BYTE_W-1:0] acc,
                                                 input logic [BYTE_W-1:0] b);
    return BYTE_W'(acc + b);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle of the instruction-memory loader.
//   Byte stream : in_valid, in_ready, in_data, in_last
//   Memory write: mem_we, mem_addr, mem_wdata
// Modports: master = stream source / memory sink, slave = the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();
  import mips_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/byte_packer.sv
// Packs a byte stream into big-endian 32-bit words.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart packing at byte 0 and zero the word
//   shift      : accept din into the low byte, older bytes move up
//   din        : stream byte
//   word       : packed word (first byte of a word lands in [31:24])
//   idx        : number of bytes already held in the current word
//   word_full  : one-cycle pulse in the cycle after the 4th byte shifted in
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] word,
  output logic [IDX_W-1:0]  idx,
  output logic              word_full
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  // Shift register, byte index and completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word      <= '0;
      idx       <= '0;
      word_full <= 1'b0;
    end else if (clr) begin
      word      <= '0;
      idx       <= '0;
      word_full <= 1'b0;
    end else begin
      word_full <= shift && (idx == LAST_IDX);
      if (shift) begin
        word <= {word[WORD_W-BYTE_W-1:0], din};
        // wraps to 0 after the 4th byte, ready for the next word
        idx  <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: packs a byte stream into big-endian words and
// writes them sequentially into instruction memory while holding the CPU
// in reset.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : one-cycle pulse opening a session (ignored while busy)
//   bus         : imem_loader_if.slave (byte stream in, memory write out)
//   cpu_rst_n   : core reset, released only after an error-free load
//   busy        : session in progress
//   done, err   : session finished / failed, sticky until next start
//   word_count  : words written in this session
// Build option IMEM_LOADER_CHECKSUM_EN: the byte flagged in_last is an
// 8-bit modulo-256 checksum of all data bytes instead of data.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_WORDS = 256   // must not exceed 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned      WC_W     = ADDR_W + 1;
  localparam logic [WC_W-1:0]  FULL_WC  = WC_W'(MEM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  loader_state_e     state;
  logic              in_ready_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              hs;
  logic              overflow_c;
  logic              pk_clr;
  logic              pk_shift;
  logic [WORD_W-1:0] pk_word;
  logic [IDX_W-1:0]  pk_idx;
  logic              pk_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum;
`else
  logic              last_q;
`endif

  assign hs = bus.in_valid & in_ready_q;

  // Memory already full when another byte arrives; a checksum byte that
  // exactly follows the final word is still legitimate.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign overflow_c = (word_count == FULL_WC) && !bus.in_last;
`else
  assign overflow_c = (word_count == FULL_WC);
`endif

  // Packer control: clear on session start, shift accepted data bytes
  always_comb begin
    pk_clr   = 1'b0;
    pk_shift = 1'b0;
    if ((state == ST_IDLE || state == ST_DONE) && start) begin
      pk_clr = 1'b1;
    end
    if (state == ST_LOAD && hs && !overflow_c) begin
      pk_shift = 1'b1;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (bus.in_last) begin
      pk_shift = 1'b0;
    end
`endif
  end

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .shift     (pk_shift),
    .din       (bus.in_data),
    .word      (pk_word),
    .idx       (pk_idx),
    .word_full (pk_full)
  );

  // The packer's completion pulse coincides with the WRITE state, and its
  // word register is stable then because in_ready is low.
  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = pk_full;
  assign bus.mem_wdata = pk_word;
  assign bus.mem_addr  = mem_addr_q;

  // Loader FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready_q <= 1'b0;
      mem_addr_q <= '0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum        <= '0;
`else
      last_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_LOAD;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_rst_n  <= 1'b0;
            word_count <= '0;
            mem_addr_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`else
            last_q     <= 1'b0;
`endif
          end
        end

        ST_LOAD: begin
          if (hs) begin
            if (overflow_c) begin
              err <= 1'b1;
              if (bus.in_last) begin
                state      <= ST_DONE;
                in_ready_q <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
              end else begin
                state <= ST_DRAIN;
              end
`ifdef IMEM_LOADER_CHECKSUM_EN
            end else if (bus.in_last) begin
              // checksum must sit on a word boundary and match the sum
              state      <= ST_DONE;
              in_ready_q <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              if ((pk_idx == '0) && (bus.in_data == sum)) begin
                cpu_rst_n <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end else begin
              sum <= sum_add(sum, bus.in_data);
              if (pk_idx == LAST_IDX) begin
                state      <= ST_WRITE;
                in_ready_q <= 1'b0;
              end
            end
`else
            end else if (pk_idx == LAST_IDX) begin
              state      <= ST_WRITE;
              in_ready_q <= 1'b0;
              last_q     <= bus.in_last;
            end else if (bus.in_last) begin
              // image ended inside a word
              state      <= ST_DONE;
              in_ready_q <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              err        <= 1'b1;
            end
`endif
          end
        end

        ST_WRITE: begin
          mem_addr_q <= mem_addr_q + ADDR_W'(1);
          word_count <= word_count + WC_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          state      <= ST_LOAD;
          in_ready_q <= 1'b1;
`else
          if (last_q) begin
            state      <= ST_DONE;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            cpu_rst_n  <= 1'b1;
          end else begin
            state      <= ST_LOAD;
            in_ready_q <= 1'b1;
          end
`endif
        end

        ST_DRAIN: begin
          // discard everything up to the end of the image
          if (hs && bus.in_last) begin
            state      <= ST_DONE;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
  import mips_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned MW = 2;
  localparam int          NV = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cpu_rst_n, busy, done, err;
  logic [AW:0]   word_count;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW), .MEM_WORDS(MW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]    stream_q[$];
  logic [31:0]   exp_q[$];
  logic          exp_err;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  typedef struct packed {
    logic [127:0] data;      // stream bytes, first byte in [127:120]
    int           len;
    int           stall_at;  // byte index preceded by 3 idle cycles, -1 none
    int           exp_wc;
    logic         exp_err;
    int           exp_nw;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_w1;
  } vec_t;

  vec_t tv [NV];

  // write log: one entry per cycle with mem_we high
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [127:0] data, input int len, input int stall_at,
                              input int wc, input logic e, input int nw,
                              input logic [31:0] w0, input logic [31:0] w1);
    vec_t v;
    v.data = data; v.len = len; v.stall_at = stall_at; v.exp_wc = wc;
    v.exp_err = e; v.exp_nw = nw; v.exp_w0 = w0; v.exp_w1 = w1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: image-level outcome from byte count, capacity and checksum.
  function automatic void model();
    int n;
    int d;
    int nw;
    logic [7:0] s;
    n = stream_q.size();
`ifdef IMEM_LOADER_CHECKSUM_EN
    d = n - 1;
`else
    d = n;
`endif
    exp_q.delete();
    if (d > 4 * int'(MW)) begin
      exp_err = 1'b1; nw = int'(MW);
    end else if (d % 4 != 0) begin
      exp_err = 1'b1; nw = d / 4;
    end else begin
      exp_err = 1'b0; nw = d / 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
      s = 8'h00;
      for (int i = 0; i < d; i++) s = s + stream_q[i];
      exp_err = (s != stream_q[n-1]);
`endif
    end
    for (int k = 0; k < nw; k++)
      exp_q.push_back({stream_q[4*k], stream_q[4*k+1], stream_q[4*k+2], stream_q[4*k+3]});
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("hs_timeout", 64'(bus.in_ready), 64'd1);
    else @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic run_session(input string tag, input int stall_at, input bit rand_stall,
                             input bit poke);
    int n;
    wa_q.delete(); wd_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
    chk({tag, " ready_after_start"}, 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < stream_q.size(); i++) begin
      if (i == stall_at) repeat (3) @(negedge clk);
      if (rand_stall && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      if (poke && i == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(stream_q[i], 1'(i == stream_q.size() - 1));
    end
    n = 0;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_session(input string tag, input int exp_wc);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " err"}, 64'(err), 64'(exp_err));
    chk({tag, " cpu_rst_n"}, 64'(cpu_rst_n), 64'(!exp_err));
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, " word_count"}, 64'(word_count), 64'(exp_wc));
    chk({tag, " nwrites"}, 64'(wd_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < wd_q.size() && k < exp_q.size(); k++) begin
      chk($sformatf("%s addr%0d", tag, k), 64'(wa_q[k]), 64'(k));
      chk($sformatf("%s data%0d", tag, k), 64'(wd_q[k]), 64'(exp_q[k]));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, " mem_we"}, 64'(bus.mem_we), 64'd0);
    chk({tag, " mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, " mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    chk({tag, " cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " err"}, 64'(err), 64'd0);
    chk({tag, " word_count"}, 64'(word_count), 64'd0);
  endtask

  initial begin
    logic [127:0] d;
    logic [7:0]   s;
    int           len;

    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
    tv[0] = mk(128'h01020304_0A000000_00000000_00000000, 5, -1, 1, 1'b0, 1, 32'h01020304, 32'h0);
    tv[1] = mk(128'h01020304_0B000000_00000000_00000000, 5, -1, 1, 1'b1, 1, 32'h01020304, 32'h0);
    tv[2] = mk(128'h01020304_00000000_00000000_00000000, 4, -1, 0, 1'b1, 0, 32'h0, 32'h0);
    tv[3] = mk(128'h20010005_20020007_4F000000_00000000, 9, -1, 2, 1'b0, 2, 32'h20010005, 32'h20020007);
    tv[4] = mk(128'h11223344_55667788_99AABBCC_00000000, 13, -1, 2, 1'b1, 2, 32'h11223344, 32'h55667788);
    tv[5] = mk(128'h00000000_00000000_00000000_00000000, 1, -1, 0, 1'b0, 0, 32'h0, 32'h0);
    tv[6] = mk(128'h20010005_20020007_4F000000_00000000, 9, 2, 2, 1'b0, 2, 32'h20010005, 32'h20020007);
`else
    tv[0] = mk(128'h20010005_20020007_00000000_00000000, 8, -1, 2, 1'b0, 2, 32'h20010005, 32'h20020007);
    tv[1] = mk(128'h20010005_20020007_00000000_00000000, 8, 2, 2, 1'b0, 2, 32'h20010005, 32'h20020007);
    tv[2] = mk(128'h20010005_AABB0000_00000000_00000000, 6, -1, 1, 1'b1, 1, 32'h20010005, 32'h0);
    tv[3] = mk(128'h11223344_55667788_99AABBCC_00000000, 12, -1, 2, 1'b1, 2, 32'h11223344, 32'h55667788);
    tv[4] = mk(128'hDEADBEEF_00000000_00000000_00000000, 4, -1, 1, 1'b0, 1, 32'hDEADBEEF, 32'h0);
    tv[5] = mk(128'h55000000_00000000_00000000_00000000, 1, -1, 0, 1'b1, 0, 32'h0, 32'h0);
    tv[6] = mk(128'hCAFEF00D_12345678_00000000_00000000, 8, 5, 2, 1'b0, 2, 32'hCAFEF00D, 32'h12345678);
`endif

    // reset values
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle in_ready", 64'(bus.in_ready), 64'd0);
    chk("idle busy", 64'(busy), 64'd0);

    // directed image table
    for (int t = 0; t < NV; t++) begin
      stream_q.delete();
      d = tv[t].data;
      for (int i = 0; i < tv[t].len; i++) stream_q.push_back(d[127-8*i -: 8]);
      exp_q.delete();
      if (tv[t].exp_nw > 0) exp_q.push_back(tv[t].exp_w0);
      if (tv[t].exp_nw > 1) exp_q.push_back(tv[t].exp_w1);
      exp_err = tv[t].exp_err;
      run_session($sformatf("vec%0d", t), tv[t].stall_at, 1'b0, 1'b0);
      check_session($sformatf("vec%0d", t), tv[t].exp_wc);
    end

    // WRITE cycle timing and done/cpu_rst_n release
    wa_q.delete(); wd_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hD4, 1'b0);
`else
    send_byte(8'hD4, 1'b1);
`endif
    chk("wr mem_we", 64'(bus.mem_we), 64'd1);
    chk("wr in_ready", 64'(bus.in_ready), 64'd0);
    chk("wr mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("wr mem_wdata", 64'(bus.mem_wdata), 64'hA1B2C3D4);
    chk("wr done", 64'(done), 64'd0);
    chk("wr cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("wr word_count", 64'(word_count), 64'd0);
    @(negedge clk);
    chk("post_wr mem_we", 64'(bus.mem_we), 64'd0);
    chk("post_wr word_count", 64'(word_count), 64'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("post_wr done", 64'(done), 64'd0);
    chk("post_wr in_ready", 64'(bus.in_ready), 64'd1);
    send_byte(8'hEA, 1'b1);
`endif
    chk("fin done", 64'(done), 64'd1);
    chk("fin cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    chk("fin busy", 64'(busy), 64'd0);
    chk("fin nwrites", 64'(wd_q.size()), 64'd1);

    // reset in the middle of a word, then a clean reload from address 0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("rst_mid");
    rst_n = 1'b1;
    @(negedge clk);
    stream_q = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream_q.push_back(8'h4F);
`endif
    model();
    run_session("reload", -1, 1'b0, 1'b0);
    check_session("reload", exp_q.size());

    // randomized images against the reference model
    for (int r = 0; r < 40; r++) begin
      stream_q.delete();
`ifdef IMEM_LOADER_CHECKSUM_EN
      len = $urandom_range(0, 10);
      s = 8'h00;
      for (int i = 0; i < len; i++) begin
        stream_q.push_back(8'($urandom));
        s = s + stream_q[i];
      end
      stream_q.push_back(($urandom_range(0, 2) != 0) ? s : 8'($urandom));
`else
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) stream_q.push_back(8'($urandom));
`endif
      model();
      run_session($sformatf("rnd%0d", r), -1, 1'b1, 1'($urandom_range(0, 1)));
      check_session($sformatf("rnd%0d", r), exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
